// File: rtl/vxe_vpu_qecu_if.sv
// Dispatcher/EU signal bundle for vxe_vpu_qecu.
// The master drives commands and EU busy; the slave is the control unit.
interface vxe_vpu_qecu_if #(
  parameter int TH_W = 3,
  parameter int PL_W = 48
);
  logic            i_disp;
  logic [4:0]      i_cmd_op;
  logic [TH_W-1:0] i_cmd_th;
  logic [PL_W-1:0] i_cmd_pl;
  logic            o_full;
  logic            o_ovf;
  logic            o_done;
  logic            o_err;
  logic            o_eu_start;
  logic [4:0]      o_eu_op;
  logic [TH_W-1:0] o_eu_th;
  logic [PL_W-1:0] o_eu_pl;
  logic            i_eu_busy;

  modport master (
    output i_disp, i_cmd_op, i_cmd_th, i_cmd_pl, i_eu_busy,
    input  o_full, o_ovf, o_done, o_err, o_eu_start, o_eu_op, o_eu_th, o_eu_pl
  );
  modport slave (
    input  i_disp, i_cmd_op, i_cmd_th, i_cmd_pl, i_eu_busy,
    output o_full, o_ovf, o_done, o_err, o_eu_start, o_eu_op, o_eu_th, o_eu_pl
  );
endinterface

// File: rtl/vxe_vpu_qecu.sv
// Queued VPU execution control unit: DEPTH-entry command FIFO feeding one EU.
// Optional busy-rise timeout enabled by defining VXE_VPU_QECU_TMO_EN.
module vxe_vpu_qecu #(
  parameter int          DEPTH   = 4,
  parameter int          TH_W    = 3,
  parameter int          PL_W    = 48,
  parameter logic [31:0] OP_MASK = 32'hFFFF_FFFF,
  parameter int          TMO_CYC = 256
) (
  input  logic           clk,
  input  logic           nrst,
  vxe_vpu_qecu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]      op;
    logic [TH_W-1:0] th;
    logic [PL_W-1:0] pl;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE} st_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  st_t             st, nxt;
  logic            push, pop, start_d, done_d, err_d;

  assign head     = mem[rd_ptr];
  assign bus.o_full = (cnt == CW'(DEPTH));
  // A same-edge pop never frees a slot for the push: full is judged on current count.
  assign push     = bus.i_disp && !bus.o_full;

`ifdef VXE_VPU_QECU_TMO_EN
  localparam int TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                tmo_cnt <= '0;
    else if (start_d)         tmo_cnt <= '0;
    else if (st == WAIT_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  always_comb begin
    nxt     = st;
    pop     = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (st)
      IDLE: if (cnt != '0) begin
        pop = 1'b1;
        if (OP_MASK[head.op]) begin
          start_d = 1'b1;
          nxt     = WAIT_BUSY;
        end else begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (bus.i_eu_busy) nxt = WAIT_IDLE;
`ifdef VXE_VPU_QECU_TMO_EN
        else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          nxt    = IDLE;
        end
`endif
      end
      WAIT_IDLE: if (!bus.i_eu_busy) begin
        done_d = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: bus.i_cmd_op, th: bus.i_cmd_th, pl: bus.i_cmd_pl};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st             <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      bus.o_ovf      <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_err      <= 1'b0;
      bus.o_eu_start <= 1'b0;
      bus.o_eu_op    <= '0;
      bus.o_eu_th    <= '0;
      bus.o_eu_pl    <= '0;
    end else begin
      st             <= nxt;
      bus.o_done     <= done_d;
      bus.o_err      <= err_d;
      bus.o_eu_start <= start_d;
      bus.o_ovf      <= bus.o_ovf | (bus.i_disp & bus.o_full);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (start_d) begin
        bus.o_eu_op <= head.op;
        bus.o_eu_th <= head.th;
        bus.o_eu_pl <= head.pl;
      end
    end
  end
endmodule

// File: tb/tb_vxe_vpu_qecu.sv
// Scoreboard bench for vxe_vpu_qecu: stimulus queues expected start/done events,
// a monitor pops and compares them whenever the DUT pulses start or done.
module tb_vxe_vpu_qecu;
  localparam logic [4:0]  STORE = 5'd2;
  localparam logic [4:0]  PROD  = 5'd3;
  localparam logic [31:0] MASK  = 32'h1 << STORE;

  typedef struct packed {
    bit          is_start;
    bit          err;
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
  } ev_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  vxe_vpu_qecu_if #(.TH_W(3), .PL_W(48)) bus ();

  vxe_vpu_qecu #(
    .DEPTH(4), .TH_W(3), .PL_W(48), .OP_MASK(MASK), .TMO_CYC(16)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  ev_t exp_q[$];
  int  n_cmp = 0, n_err = 0;
  int  n_start = 0, n_done = 0, cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
  bit  eu_auto = 1'b0, man_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every start/done pulse must match the head of the expected queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (nrst) begin
        if (bus.o_eu_start) begin
          n_start++; last_start_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_start: got start th=%0d want none", bus.o_eu_th);
          end else begin
            e = exp_q.pop_front();
            chk("start_kind", 64'(bus.o_eu_start), 64'(e.is_start));
            chk("start_op", 64'(bus.o_eu_op), 64'(e.op));
            chk("start_th", 64'(bus.o_eu_th), 64'(e.th));
            chk("start_pl", 64'(bus.o_eu_pl), 64'(e.pl));
          end
        end
        if (bus.o_done) begin
          n_done++; last_done_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got done err=%0d want none", bus.o_err);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", 64'(!e.is_start), 64'(1));
            chk("done_err", 64'(bus.o_err), 64'(e.err));
          end
        end
      end
    end
  end

  // EU model: auto mode raises busy one cycle after start for 8 cycles; manual follows man_busy.
  initial begin
    bus.i_eu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!eu_auto) bus.i_eu_busy = man_busy;
      else if (bus.o_eu_start && nrst) begin
        @(negedge clk);
        bus.i_eu_busy = 1'b1;
        repeat (8) @(negedge clk);
        bus.i_eu_busy = 1'b0;
      end
    end
  end

  task automatic disp(input logic [4:0] op, input logic [2:0] th, input logic [47:0] pl,
                      input bit drop, input bit tmo);
    logic [31:0] m;
    m = MASK;
    bus.i_disp = 1'b1; bus.i_cmd_op = op; bus.i_cmd_th = th; bus.i_cmd_pl = pl;
    if (!drop) begin
      if (m[op]) exp_q.push_back('{is_start: 1'b1, err: 1'b0, op: op, th: th, pl: pl});
      exp_q.push_back('{is_start: 1'b0, err: (!m[op]) || tmo, op: op, th: th, pl: pl});
    end
    @(negedge clk);
    bus.i_disp = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  // Let the held EU go idle, wait for the blocker's done, then hand the EU to auto mode.
  task automatic release_eu(input string name);
    bit seen;
    seen = 1'b0;
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    man_busy = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.o_done;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'(1));
    chk({name, "_full_until_pop"}, 64'(bus.o_full), 64'(1));
    eu_auto = 1'b1;
    @(negedge clk);
    chk({name, "_full_after_pop"}, 64'(bus.o_full), 64'(0));
  endtask

  initial begin
    int s0, d0;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0, d0;
    bus.i_disp = 1'b0; bus.i_cmd_op = '0; bus.i_cmd_th = '0; bus.i_cmd_pl = '0;
    #12;
    chk("rst_full", 64'(bus.o_full), 64'(0));
    chk("rst_ovf", 64'(bus.o_ovf), 64'(0));
    chk("rst_done", 64'(bus.o_done), 64'(0));
    chk("rst_err", 64'(bus.o_err), 64'(0));
    chk("rst_start", 64'(bus.o_eu_start), 64'(0));
    chk("rst_eu", 64'({bus.o_eu_op, bus.o_eu_th, bus.o_eu_pl}), 64'(0));
    @(negedge clk); nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single accepted store, start two edges after dispatch
    eu_auto = 1'b1;
    disp(STORE, 3'd5, 48'h1234_5678_9ABC, 1'b0, 1'b0);
    chk("t1_no_early_start", 64'(bus.o_eu_start), 64'(0));
    @(negedge clk);
    chk("t1_start_lat", 64'(bus.o_eu_start), 64'(1));
    drain("t1_drain");

    // 2: rejected opcode, then busy toggles without a command
    disp(PROD, 3'd1, 48'h77, 1'b0, 1'b0);
    drain("t2_drain");
    eu_auto = 1'b0; d0 = n_done;
    man_busy = 1'b1; repeat (3) @(negedge clk);
    man_busy = 1'b0; repeat (5) @(negedge clk);
    chk("t2_no_extra_done", 64'(n_done), 64'(d0));

    // 3: blocker holds the FSM so four queued commands fill the FIFO
    s0 = n_start;
    disp(STORE, 3'd7, 48'hA, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) disp(STORE, 3'(i), 48'(i), 1'b0, 1'b0);
    chk("t3_full", 64'(bus.o_full), 64'(1));
    release_eu("t3");
    drain("t3_drain");
    chk("t3_starts", 64'(n_start - s0), 64'(5));

    // 4: overflow while the EU is held busy
    eu_auto = 1'b0; man_busy = 1'b1; d0 = n_done;
    repeat (2) @(negedge clk);
    chk("t4_ovf_clear", 64'(bus.o_ovf), 64'(0));
    disp(STORE, 3'd6, 48'hB0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) disp(STORE, 3'(i), 48'h100 + 48'(i), 1'b0, 1'b0);
    chk("t4_full", 64'(bus.o_full), 64'(1));
    chk("t4_ovf_before", 64'(bus.o_ovf), 64'(0));
    disp(STORE, 3'd5, 48'h1FF, 1'b1, 1'b0);
    chk("t4_ovf_set", 64'(bus.o_ovf), 64'(1));
    release_eu("t4");
    drain("t4_drain");
    chk("t4_ovf_sticky", 64'(bus.o_ovf), 64'(1));
    chk("t4_dones", 64'(n_done - d0), 64'(5));  // blocker plus four kept commands

    // 5: asynchronous reset in WAIT_IDLE with two commands queued
    eu_auto = 1'b0; man_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) disp(STORE, 3'(i + 1), 48'h500 + 48'(i), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t5_rst_full", 64'(bus.o_full), 64'(0));
    chk("t5_rst_ovf", 64'(bus.o_ovf), 64'(0));
    chk("t5_rst_pulses", 64'({bus.o_done, bus.o_err, bus.o_eu_start}), 64'(0));
    chk("t5_rst_eu", 64'({bus.o_eu_op, bus.o_eu_th, bus.o_eu_pl}), 64'(0));
    exp_q.delete();
    man_busy = 1'b0;
    @(negedge clk); nrst = 1'b1;
    s0 = n_start; d0 = n_done;
    repeat (20) @(negedge clk);
    chk("t5_no_start", 64'(n_start), 64'(s0));
    chk("t5_no_done", 64'(n_done), 64'(d0));

`ifdef VXE_VPU_QECU_TMO_EN
    // 6: busy never rises, timeout retires the command with an error
    disp(STORE, 3'd2, 48'hC, 1'b0, 1'b1);
    drain("t6_drain");
    chk("t6_tmo_cycles", 64'(last_done_cyc - last_start_cyc), 64'(16));
    d0 = n_done;
    man_busy = 1'b1; repeat (3) @(negedge clk);
    man_busy = 1'b0; repeat (5) @(negedge clk);
    chk("t6_late_busy", 64'(n_done), 64'(d0));
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
